// File: rtl/taylor_coeff_seq.sv
// rtl/taylor_coeff_seq.sv - Taylor coefficient ROM sequencer feeding a valid/ready MAC stream
// Optional macro TAYLOR_SEQ_HORNER_EN: stream indices num_terms-1 down to 0 instead of ascending.
module taylor_coeff_seq #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_COEFF  = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_terms,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rom_rd,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  coeff_valid,
    input  logic                  coeff_ready,
    output logic [DATA_WIDTH-1:0] coeff_data,
    output logic [ADDR_WIDTH-1:0] coeff_idx,
    output logic                  coeff_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [ADDR_WIDTH:0] MAX_TERMS = (ADDR_WIDTH + 1)'(NUM_COEFF);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] terms, rd_addr, rd_first, rd_step;
    logic                  rd_final, start_ok, issue_ok, flush;
    logic                  inflight, inflight_last;
    logic [ADDR_WIDTH-1:0] inflight_idx;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [ADDR_WIDTH-1:0] fifo_idx  [2];
    logic                  fifo_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic                  has_entries, use_bypass, pop, push_store, pop_fifo;

`ifdef TAYLOR_SEQ_HORNER_EN
    assign rd_first = num_terms - ADDR_WIDTH'(1);
    assign rd_step  = rd_addr - ADDR_WIDTH'(1);
    assign rd_final = (rd_addr == '0);
`else
    assign rd_first = '0;
    assign rd_step  = rd_addr + ADDR_WIDTH'(1);
    assign rd_final = (rd_addr == terms - ADDR_WIDTH'(1));
`endif

    assign start_ok = start && (num_terms != '0) && ({1'b0, num_terms} <= MAX_TERMS);
    assign issue_ok = (count + {1'b0, inflight}) < 2'd2;
    assign flush    = abort && (state != IDLE);
    assign busy     = (state != IDLE);
    assign rom_addr = rd_addr;

    // Returning data is presented straight from rom_data when the FIFO is empty,
    // so a coefficient is visible the same cycle it arrives.
    assign has_entries = (count != 2'd0);
    assign use_bypass  = !has_entries && inflight;
    assign coeff_valid = has_entries || inflight;
    assign coeff_data  = !coeff_valid ? '0 : (use_bypass ? rom_data      : fifo_data[rd_ptr]);
    assign coeff_idx   = !coeff_valid ? '0 : (use_bypass ? inflight_idx  : fifo_idx[rd_ptr]);
    assign coeff_last  = coeff_valid && (use_bypass ? inflight_last : fifo_last[rd_ptr]);
    assign pop         = coeff_valid && coeff_ready;
    assign push_store  = inflight && !(use_bypass && pop);
    assign pop_fifo    = pop && has_entries;
    assign done        = (state == DRAIN) && !abort && pop && coeff_last;

    always_comb begin
        state_nxt = state;
        rom_rd    = 1'b0;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (issue_ok) begin
                    rom_rd = 1'b1;
                    if (rd_final) state_nxt = DRAIN;
                end
            end
            DRAIN:   if (abort || done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            terms         <= '0;
            rd_addr       <= '0;
            err           <= 1'b0;
            inflight      <= 1'b0;
            inflight_idx  <= '0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            state    <= state_nxt;
            err      <= (state == IDLE) && start && !start_ok;
            inflight <= rom_rd;
            if (state == IDLE && start_ok) begin
                terms   <= num_terms;
                rd_addr <= rd_first;
            end else if (rom_rd) begin
                inflight_idx  <= rd_addr;
                inflight_last <= rd_final;
                if (!rd_final) rd_addr <= rd_step;
            end
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push_store) begin
                    fifo_data[wr_ptr] <= rom_data;
                    fifo_idx[wr_ptr]  <= inflight_idx;
                    fifo_last[wr_ptr] <= inflight_last;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop_fifo) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push_store} - {1'b0, pop_fifo};
            end
        end
    end
endmodule

// File: tb/tb_taylor_coeff_seq.sv
// tb/tb_taylor_coeff_seq.sv - directed self-checking bench for taylor_coeff_seq
module tb_taylor_coeff_seq;
    localparam int AW = 6;
    localparam int DW = 32;
`ifdef TAYLOR_SEQ_HORNER_EN
    localparam bit HORNER = 1'b1;
`else
    localparam bit HORNER = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, coeff_ready = 1'b0;
    logic [AW-1:0] num_terms = '0;
    logic          busy, done, err, rom_rd, coeff_valid, coeff_last;
    logic [AW-1:0] rom_addr, coeff_idx;
    logic [DW-1:0] rom_data = '0;
    logic [DW-1:0] coeff_data;
    int            checks = 0, passes = 0;

    taylor_coeff_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COEFF(33)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .abort(abort),
        .busy(busy), .done(done), .err(err), .rom_rd(rom_rd), .rom_addr(rom_addr),
        .rom_data(rom_data), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .coeff_data(coeff_data), .coeff_idx(coeff_idx), .coeff_last(coeff_last)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM whose word encodes its own address.
    always @(posedge clk) if (rom_rd) rom_data <= 32'hC0FE_0000 | 32'(rom_addr);

    function automatic logic [AW-1:0] exp_idx(input int n, input int k);
        logic [AW-1:0] asc, desc;
        asc  = AW'(k);
        desc = AW'(n - 1 - k);
        return HORNER ? desc : asc;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] i);
        return 32'hC0FE_0000 | 32'(i);
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)        $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (done !== 1'b0)        $display("FAIL reset_done got=%b exp=0", done); else passes++;
        checks++; if (err !== 1'b0)         $display("FAIL reset_err got=%b exp=0", err); else passes++;
        checks++; if (rom_rd !== 1'b0)      $display("FAIL reset_rom_rd got=%b exp=0", rom_rd); else passes++;
        checks++; if (coeff_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", coeff_valid); else passes++;
        checks++; if (coeff_last !== 1'b0)  $display("FAIL reset_last got=%b exp=0", coeff_last); else passes++;
        checks++; if (rom_addr !== '0)      $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); else passes++;
        checks++; if (coeff_data !== '0)    $display("FAIL reset_data got=%h exp=0", coeff_data); else passes++;
        checks++; if (coeff_idx !== '0)     $display("FAIL reset_idx got=%h exp=0", coeff_idx); else passes++;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(posedge clk); #1 start = 1'b1; num_terms = 6'd4; coeff_ready = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_c0 got=%b exp=0", busy); else passes++;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start     = (c == 3);
            num_terms = (c == 3) ? 6'd0 : 6'd4;
            @(negedge clk);
            checks++; if (busy !== (c <= 5)) $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, c <= 5); else passes++;
            checks++; if (err !== 1'b0) $display("FAIL basic_err c=%0d got=%b exp=0", c, err); else passes++;
            checks++; if (rom_rd !== (c <= 4)) $display("FAIL basic_rom_rd c=%0d got=%b exp=%b", c, rom_rd, c <= 4); else passes++;
            if (c <= 4) begin
                checks++; if (rom_addr !== exp_idx(4, c - 1)) $display("FAIL basic_rom_addr c=%0d got=%0d exp=%0d", c, rom_addr, exp_idx(4, c - 1)); else passes++;
            end
            checks++; if (coeff_valid !== (c >= 2 && c <= 5)) $display("FAIL basic_valid c=%0d got=%b", c, coeff_valid); else passes++;
            if (c >= 2 && c <= 5) begin
                checks++; if (coeff_idx !== exp_idx(4, c - 2)) $display("FAIL basic_idx c=%0d got=%0d exp=%0d", c, coeff_idx, exp_idx(4, c - 2)); else passes++;
                checks++; if (coeff_data !== exp_data(exp_idx(4, c - 2))) $display("FAIL basic_data c=%0d got=%h exp=%h", c, coeff_data, exp_data(exp_idx(4, c - 2))); else passes++;
                checks++; if (coeff_last !== (c == 5)) $display("FAIL basic_last c=%0d got=%b exp=%b", c, coeff_last, c == 5); else passes++;
            end
            checks++; if (done !== (c == 5)) $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, c == 5); else passes++;
        end
        start = 1'b0;
    endtask

    task automatic test_reject(input logic [AW-1:0] n);
        @(posedge clk); #1 start = 1'b1; num_terms = n;
        @(negedge clk);
        checks++; if (rom_rd !== 1'b0) $display("FAIL rej_rom_rd_c0 n=%0d got=%b exp=0", n, rom_rd); else passes++;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b1)    $display("FAIL rej_err n=%0d got=%b exp=1", n, err); else passes++;
        checks++; if (busy !== 1'b0)   $display("FAIL rej_busy n=%0d got=%b exp=0", n, busy); else passes++;
        checks++; if (rom_rd !== 1'b0) $display("FAIL rej_rom_rd n=%0d got=%b exp=0", n, rom_rd); else passes++;
        @(negedge clk);
        checks++; if (err !== 1'b0)    $display("FAIL rej_err_pulse n=%0d got=%b exp=0", n, err); else passes++;
        checks++; if (busy !== 1'b0)   $display("FAIL rej_busy2 n=%0d got=%b exp=0", n, busy); else passes++;
    endtask

    task automatic test_single();
        @(posedge clk); #1 start = 1'b1; abort = 1'b1; num_terms = 6'd1; coeff_ready = 1'b0;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1)        $display("FAIL single_busy got=%b exp=1", busy); else passes++;
        checks++; if (rom_rd !== 1'b1 || rom_addr !== '0) $display("FAIL single_rd got=%b/%0d exp=1/0", rom_rd, rom_addr); else passes++;
        @(negedge clk);
        checks++; if (coeff_valid !== 1'b1 || coeff_idx !== '0 || coeff_last !== 1'b1) $display("FAIL single_entry got=%b/%0d/%b exp=1/0/1", coeff_valid, coeff_idx, coeff_last); else passes++;
        checks++; if (done !== 1'b0)        $display("FAIL single_done_stall got=%b exp=0", done); else passes++;
        checks++; if (rom_rd !== 1'b0)      $display("FAIL single_no_extra_rd got=%b exp=0", rom_rd); else passes++;
        @(posedge clk); #1 coeff_ready = 1'b1;
        @(negedge clk);
        checks++; if (coeff_valid !== 1'b1 || coeff_data !== exp_data('0)) $display("FAIL single_held got=%b/%h exp=1/%h", coeff_valid, coeff_data, exp_data('0)); else passes++;
        checks++; if (done !== 1'b1)        $display("FAIL single_done got=%b exp=1", done); else passes++;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || coeff_valid !== 1'b0) $display("FAIL single_idle got=%b/%b exp=0/0", busy, coeff_valid); else passes++;
    endtask

    task automatic test_stall();
        int            got = 0, issued = 0;
        bit            fin = 1'b0;
        logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [AW-1:0] pi = '0;
        @(posedge clk); #1 start = 1'b1; num_terms = 6'd8; coeff_ready = 1'b0;
        for (int c = 1; c < 60 && !fin; c++) begin
            @(posedge clk); #1 start = 1'b0; coeff_ready = c[0];
            @(negedge clk);
            if (rom_rd) begin
                checks++; if (rom_addr !== exp_idx(8, issued)) $display("FAIL stall_rom_addr got=%0d exp=%0d", rom_addr, exp_idx(8, issued)); else passes++;
                checks++; if (issued - got >= 2) $display("FAIL stall_outstanding got=%0d exp=<2", issued - got); else passes++;
                issued++;
            end
            if (pv && !pr) begin
                checks++; if ({coeff_valid, coeff_data, coeff_idx, coeff_last} !== {1'b1, pd, pi, pl})
                    $display("FAIL stall_stable got=%b/%h/%0d/%b exp=1/%h/%0d/%b", coeff_valid, coeff_data, coeff_idx, coeff_last, pd, pi, pl); else passes++;
            end
            if (coeff_valid && coeff_ready) begin
                checks++; if (coeff_idx !== exp_idx(8, got)) $display("FAIL stall_idx got=%0d exp=%0d", coeff_idx, exp_idx(8, got)); else passes++;
                checks++; if (coeff_data !== exp_data(exp_idx(8, got))) $display("FAIL stall_data got=%h exp=%h", coeff_data, exp_data(exp_idx(8, got))); else passes++;
                checks++; if (coeff_last !== (got == 7) || done !== (got == 7)) $display("FAIL stall_last_done got=%b/%b exp=%b", coeff_last, done, got == 7); else passes++;
                got++;
                fin = (got == 8);
            end else begin
                checks++; if (done !== 1'b0) $display("FAIL stall_spurious_done got=%b exp=0", done); else passes++;
            end
            pv = coeff_valid; pr = coeff_ready; pd = coeff_data; pi = coeff_idx; pl = coeff_last;
        end
        checks++; if (got != 8 || issued != 8) $display("FAIL stall_count got=%0d/%0d exp=8/8", got, issued); else passes++;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || coeff_valid !== 1'b0) $display("FAIL stall_idle got=%b/%b exp=0/0", busy, coeff_valid); else passes++;
    endtask

    task automatic test_abort();
        @(posedge clk); #1 start = 1'b1; num_terms = 6'd33; coeff_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1 start = 1'b0; abort = (c == 6);
            @(negedge clk);
            if (c == 6) begin
                checks++; if (coeff_valid !== 1'b1 || coeff_idx !== exp_idx(33, 4)) $display("FAIL abort_5th got=%b/%0d exp=1/%0d", coeff_valid, coeff_idx, exp_idx(33, 4)); else passes++;
            end
            checks++; if (done !== 1'b0) $display("FAIL abort_done c=%0d got=%b exp=0", c, done); else passes++;
            if (c >= 7) begin
                checks++; if ({busy, coeff_valid, rom_rd} !== 3'b000) $display("FAIL abort_idle c=%0d got=%b exp=000", c, {busy, coeff_valid, rom_rd}); else passes++;
            end
        end
        abort = 1'b0;
        @(posedge clk); #1 start = 1'b1; num_terms = 6'd2;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            checks++; if (coeff_valid !== (c == 2 || c == 3)) $display("FAIL abort_re_valid c=%0d got=%b", c, coeff_valid); else passes++;
            if (c == 2 || c == 3) begin
                checks++; if (coeff_idx !== exp_idx(2, c - 2) || coeff_data !== exp_data(exp_idx(2, c - 2))) $display("FAIL abort_re_entry c=%0d got=%0d/%h exp=%0d", c, coeff_idx, coeff_data, exp_idx(2, c - 2)); else passes++;
            end
            checks++; if (done !== (c == 3) || coeff_last !== (c == 3)) $display("FAIL abort_re_done c=%0d got=%b/%b exp=%b", c, done, coeff_last, c == 3); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 start = 1'b1; num_terms = 6'd10; coeff_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1 start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, err, rom_rd, coeff_valid, coeff_last} !== 6'b0) $display("FAIL rstmid_flags got=%b exp=000000", {busy, done, err, rom_rd, coeff_valid, coeff_last}); else passes++;
        checks++; if (rom_addr !== '0 || coeff_idx !== '0 || coeff_data !== '0) $display("FAIL rstmid_buses got=%0d/%0d/%h exp=0", rom_addr, coeff_idx, coeff_data); else passes++;
        @(posedge clk); #2 rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            checks++; if ({done, coeff_valid, busy} !== 3'b000) $display("FAIL rstmid_after c=%0d got=%b exp=000", c, {done, coeff_valid, busy}); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject(6'd0);
        test_reject(6'd34);
        test_single();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
